// File: rtl/leitor_botoes.sv
// Push-button front end: 2-flop sync, per-button debounce FSM, one-cycle press pulses.
// Optional auto-repeat while held is enabled by defining LEITOR_BOTOES_REPETE_EN.
module leitor_botoes #(
  parameter int N_BOTOES        = 8,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int REPETE_CICLOS   = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] botoes_in,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] pulsos,
  output logic [N_BOTOES-1:0] estavel,
  output logic                algum
);

  localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

`ifdef LEITOR_BOTOES_REPETE_EN
  localparam int RW = (REPETE_CICLOS > 2) ? $clog2(REPETE_CICLOS) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPETE_CICLOS - 1);
`endif

  typedef enum logic [1:0] {
    SOLTO,
    CONF_PRESS,
    PRESSIONADO,
    CONF_SOLTA
  } estado_t;

  logic [N_BOTOES-1:0] s1_q;
  logic [N_BOTOES-1:0] s2_q;

  estado_t       estado_q [N_BOTOES];
  estado_t       estado_d [N_BOTOES];
  logic [CW-1:0] cnt_q    [N_BOTOES];
  logic [CW-1:0] cnt_d    [N_BOTOES];

  logic [N_BOTOES-1:0] estavel_q;
  logic [N_BOTOES-1:0] estavel_d;
  logic [N_BOTOES-1:0] pulsos_q;
  logic [N_BOTOES-1:0] pulsos_d;

`ifdef LEITOR_BOTOES_REPETE_EN
  logic [RW-1:0] rep_q [N_BOTOES];
  logic [RW-1:0] rep_d [N_BOTOES];
`endif

  always_comb begin
    for (int i = 0; i < N_BOTOES; i++) begin
      estado_d[i]  = estado_q[i];
      cnt_d[i]     = cnt_q[i];
      estavel_d[i] = estavel_q[i];
      pulsos_d[i]  = 1'b0;
`ifdef LEITOR_BOTOES_REPETE_EN
      rep_d[i]     = rep_q[i];
`endif
      unique case (estado_q[i])
        SOLTO: begin
          if (s2_q[i]) begin
            estado_d[i] = CONF_PRESS;
            cnt_d[i]    = '0;
          end
        end
        CONF_PRESS: begin
          if (!s2_q[i]) begin
            estado_d[i] = SOLTO;
          end else if (cnt_q[i] == CNT_MAX) begin
            estado_d[i]  = PRESSIONADO;
            estavel_d[i] = 1'b1;
            pulsos_d[i]  = habilita;
`ifdef LEITOR_BOTOES_REPETE_EN
            rep_d[i]     = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSIONADO: begin
          if (!s2_q[i]) begin
            estado_d[i] = CONF_SOLTA;
            cnt_d[i]    = '0;
          end
        end
        CONF_SOLTA: begin
          if (s2_q[i]) begin
            estado_d[i] = PRESSIONADO;
          end else if (cnt_q[i] == CNT_MAX) begin
            estado_d[i]  = SOLTO;
            estavel_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          estado_d[i] = SOLTO;
        end
      endcase
`ifdef LEITOR_BOTOES_REPETE_EN
      // Repeat timer runs across held and release-bounce states alike
      if (estado_q[i] == PRESSIONADO || estado_q[i] == CONF_SOLTA) begin
        if (rep_q[i] == REP_MAX) begin
          rep_d[i]    = '0;
          pulsos_d[i] = habilita;
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end
      if (estado_d[i] == SOLTO) begin
        rep_d[i] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      estavel_q <= '0;
      pulsos_q  <= '0;
      for (int i = 0; i < N_BOTOES; i++) begin
        estado_q[i] <= SOLTO;
        cnt_q[i]    <= '0;
`ifdef LEITOR_BOTOES_REPETE_EN
        rep_q[i]    <= '0;
`endif
      end
    end else begin
      s1_q      <= botoes_in;
      s2_q      <= s1_q;
      estavel_q <= estavel_d;
      pulsos_q  <= pulsos_d;
      for (int i = 0; i < N_BOTOES; i++) begin
        estado_q[i] <= estado_d[i];
        cnt_q[i]    <= cnt_d[i];
`ifdef LEITOR_BOTOES_REPETE_EN
        rep_q[i]    <= rep_d[i];
`endif
      end
    end
  end

  assign pulsos  = pulsos_q;
  assign estavel = estavel_q;
  assign algum   = |pulsos_q;

endmodule

// File: tb/tb_leitor_botoes.sv
// Directed bench for leitor_botoes with DEBOUNCE_CICLOS=4, REPETE_CICLOS=8.
// Input applied before edge E1 gives a pulse sampled after edge E1+6.
module tb_leitor_botoes;

  logic       clk;
  logic       rst_n;
  logic [7:0] botoes_in;
  logic       habilita;
  logic [7:0] pulsos;
  logic [7:0] estavel;
  logic       algum;

  int checks;
  int passed;

  leitor_botoes #(
    .N_BOTOES(8),
    .DEBOUNCE_CICLOS(4),
    .REPETE_CICLOS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .botoes_in(botoes_in),
    .habilita(habilita),
    .pulsos(pulsos),
    .estavel(estavel),
    .algum(algum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0;
    botoes_in = 8'hFF;
    idle(3);
    checks++;
    if (pulsos !== 8'h00 || estavel !== 8'h00 || algum !== 1'b0)
      $display("FAIL reset_hold pulsos=%h estavel=%h algum=%b want 00/00/0",
               pulsos, estavel, algum);
    else passed++;
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      e = (k == 7) ? 8'hFF : 8'h00;
      checks++;
      if (pulsos !== e)
        $display("FAIL reset_release k=%0d pulsos=%h want %h", k, pulsos, e);
      else passed++;
    end
    checks++;
    if (estavel !== 8'hFF)
      $display("FAIL reset_estavel estavel=%h want ff", estavel);
    else passed++;
    // Asynchronous assertion: checked between clock edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (estavel !== 8'h00 || pulsos !== 8'h00)
      $display("FAIL reset_async estavel=%h pulsos=%h want 00/00", estavel, pulsos);
    else passed++;
    botoes_in = 8'h00;
    tick();
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_press_b0();
    logic [7:0] e;
    logic       ee;
    botoes_in = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      tick();
`ifdef LEITOR_BOTOES_REPETE_EN
      e = (k == 7 || k == 15) ? 8'h01 : 8'h00;
`else
      e = (k == 7) ? 8'h01 : 8'h00;
`endif
      checks++;
      if (pulsos !== e || algum !== (e != 8'h00))
        $display("FAIL press_b0 k=%0d pulsos=%h algum=%b want %h", k, pulsos, algum, e);
      else passed++;
    end
    botoes_in = 8'h00;
    for (int j = 1; j <= 10; j++) begin
      tick();
`ifdef LEITOR_BOTOES_REPETE_EN
      e = (j == 3) ? 8'h01 : 8'h00;
`else
      e = 8'h00;
`endif
      ee = (j < 7);
      checks++;
      if (pulsos !== e || estavel[0] !== ee)
        $display("FAIL release_b0 j=%0d pulsos=%h estavel0=%b want %h/%b",
                 j, pulsos, estavel[0], e, ee);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 12; k++) begin
      botoes_in = (k <= 3) ? 8'h08 : 8'h00;
      tick();
      checks++;
      if (pulsos !== 8'h00 || estavel[3] !== 1'b0)
        $display("FAIL glitch_b3 k=%0d pulsos=%h estavel3=%b want 00/0",
                 k, pulsos, estavel[3]);
      else passed++;
    end
  endtask

  task automatic test_release_bounce();
    logic [7:0] e;
    logic       ee;
    botoes_in = 8'h04;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k == 7) ? 8'h04 : 8'h00;
      checks++;
      if (pulsos !== e)
        $display("FAIL bounce_press k=%0d pulsos=%h want %h", k, pulsos, e);
      else passed++;
    end
    // low 2, high 1, low 10: final fall sampled at edge 4
    for (int j = 1; j <= 13; j++) begin
      botoes_in = (j == 3) ? 8'h04 : 8'h00;
      tick();
`ifdef LEITOR_BOTOES_REPETE_EN
      e = (j == 7) ? 8'h04 : 8'h00;
`else
      e = 8'h00;
`endif
      ee = (j < 10);
      checks++;
      if (pulsos !== e || estavel[2] !== ee)
        $display("FAIL bounce_release j=%0d pulsos=%h estavel2=%b want %h/%b",
                 j, pulsos, estavel[2], e, ee);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    botoes_in = 8'h82;
    for (int k = 1; k <= 9; k++) begin
      tick();
      e = (k == 7) ? 8'h82 : 8'h00;
      checks++;
      if (pulsos !== e || algum !== (e != 8'h00))
        $display("FAIL simult k=%0d pulsos=%h algum=%b want %h", k, pulsos, algum, e);
      else passed++;
    end
    botoes_in = 8'h00;
    idle(12);
    habilita = 1'b0;
    botoes_in = 8'h82;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (pulsos !== 8'h00 || algum !== 1'b0)
        $display("FAIL masked k=%0d pulsos=%h algum=%b want 00/0", k, pulsos, algum);
      else passed++;
    end
    checks++;
    if (estavel !== 8'h82)
      $display("FAIL masked_estavel estavel=%h want 82", estavel);
    else passed++;
    habilita = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (pulsos !== 8'h00)
        $display("FAIL no_replay k=%0d pulsos=%h want 00", k, pulsos);
      else passed++;
    end
    botoes_in = 8'h00;
    idle(12);
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    botoes_in = 8'h20;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (pulsos !== 8'h00)
        $display("FAIL mid_pre k=%0d pulsos=%h want 00", k, pulsos);
      else passed++;
    end
    rst_n = 1'b0;
    idle(2);
    checks++;
    if (pulsos !== 8'h00 || estavel !== 8'h00)
      $display("FAIL mid_in_reset pulsos=%h estavel=%h want 00/00", pulsos, estavel);
    else passed++;
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      e = (k == 7) ? 8'h20 : 8'h00;
      checks++;
      if (pulsos !== e)
        $display("FAIL mid_after k=%0d pulsos=%h want %h", k, pulsos, e);
      else passed++;
    end
    botoes_in = 8'h00;
    idle(12);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    botoes_in = 8'h00;
    habilita = 1'b1;
    test_reset();
    test_press_b0();
    test_glitch();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
